// File: rtl/uart_pkg.sv
// Shared definitions for the UART datapath: transmitter state encoding,
// oversampling ratio and tick-counter width.
`timescale 1ns/1ps
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // True on the final tick of a period that is len ticks long.
  function automatic logic last_tick(input logic [TICK_CNT_W-1:0] cnt,
                                     input int unsigned len);
    return cnt == TICK_CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even parity
// (enabled by defining UART_TX_PARITY_EN), SB_TICK-tick stop bit.
`timescale 1ns/1ps
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  localparam int NBIT_W = 3;

  uart_tx_state_t        state_q, state_d;
  logic [TICK_CNT_W-1:0] s_q, s_d;
  logic [NBIT_W-1:0]     n_q, n_d;
  logic [DBIT-1:0]       b_q, b_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Frame payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    b_q   <= b_d;
`ifdef UART_TX_PARITY_EN
    par_q <= par_d;
`endif
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (last_tick(s_q, OVERSAMPLE)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (last_tick(s_q, OVERSAMPLE)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == NBIT_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (last_tick(s_q, OVERSAMPLE)) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (last_tick(s_q, SB_TICK)) begin
            s_d     = '0;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx moves on the same edge
  // as the state change, including the fall on accept.
  always_comb begin
    tx_d   = 1'b1;
    done_d = (state_q == STOP) && s_tick && last_tick(s_q, SB_TICK);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign busy         = (state_q != IDLE);
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (SB_TICK 16 with varied tick patterns,
// SB_TICK 32 with ticks every clock) checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic       clk, rstn;
  logic       tx_start_a [2];
  logic       s_tick_a   [2];
  logic [7:0] din_a      [2];
  logic       tx_a       [2];
  logic       busy_a     [2];
  logic       done_a     [2];

  int n_cmp = 0;
  int n_err = 0;
  int tick_mode = 0;
  int div = 0;
  int dcnt [2] = '{0, 0};
  int bcnt1 = 0;
  int hcnt1 = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a frame is a list of (level, length-in-ticks) pairs consumed by s_tick.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int SBT = (g == 0) ? 16 : 32;

    uart_tx #(.DBIT(8), .SB_TICK(SBT)) u_dut (
      .clk          (clk),
      .rstn         (rstn),
      .tx_start     (tx_start_a[g]),
      .s_tick       (s_tick_a[g]),
      .din          (din_a[g]),
      .tx           (tx_a[g]),
      .busy         (busy_a[g]),
      .tx_done_tick (done_a[g])
    );

    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit e_tx   = 1'b1;
    int m_cnt  = 0;
    bit lvl_q [$];
    int len_q [$];

    initial forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_cnt  = 0;
        lvl_q.delete();
        len_q.delete();
      end else begin
        m_done = 1'b0;
        if (!m_busy) begin
          if (tx_start_a[g]) begin
            lvl_q.delete();
            len_q.delete();
            lvl_q.push_back(1'b0);
            len_q.push_back(16);
            for (int i = 0; i < 8; i++) begin
              lvl_q.push_back(din_a[g][i]);
              len_q.push_back(16);
            end
            if (NPAR == 1) begin
              lvl_q.push_back(^din_a[g]);
              len_q.push_back(16);
            end
            lvl_q.push_back(1'b1);
            len_q.push_back(SBT);
            m_busy = 1'b1;
            m_cnt  = 0;
          end
        end else if (s_tick_a[g]) begin
          m_cnt++;
          if (m_cnt == len_q[0]) begin
            void'(lvl_q.pop_front());
            void'(len_q.pop_front());
            m_cnt = 0;
            if (lvl_q.size() == 0) begin
              m_busy = 1'b0;
              m_done = 1'b1;
            end
          end
        end
      end
      e_tx = m_busy ? lvl_q[0] : 1'b1;
    end
  end

  // Oversampling tick for instance 0: 1-in-10 divider, random, or every clock.
  initial begin
    s_tick_a[0] = 1'b0;
    div = $urandom_range(0, 9);
    forever begin
      @(posedge clk);
      #1;
      case (tick_mode)
        0: begin
          s_tick_a[0] = (div == 0);
          div = (div == 9) ? 0 : div + 1;
        end
        1:       s_tick_a[0] = ($urandom_range(0, 3) == 0);
        default: s_tick_a[0] = 1'b1;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_out(input int idx, input logic tx, input logic bsy, input logic dn,
                         input bit etx, input bit ebsy, input bit edn);
    n_cmp += 3;
    if (tx !== etx) begin
      n_err++;
      $display("FAIL u%0d tx: got %b expected %b at %0t", idx, tx, etx, $time);
    end
    if (bsy !== ebsy) begin
      n_err++;
      $display("FAIL u%0d busy: got %b expected %b at %0t", idx, bsy, ebsy, $time);
    end
    if (dn !== edn) begin
      n_err++;
      $display("FAIL u%0d done: got %b expected %b at %0t", idx, dn, edn, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    cmp_out(0, tx_a[0], busy_a[0], done_a[0], g_dut[0].e_tx, g_dut[0].m_busy, g_dut[0].m_done);
    cmp_out(1, tx_a[1], busy_a[1], done_a[1], g_dut[1].e_tx, g_dut[1].m_busy, g_dut[1].m_done);
    if (done_a[0] === 1'b1) dcnt[0]++;
    if (done_a[1] === 1'b1) dcnt[1]++;
    if (busy_a[1] === 1'b1) begin
      bcnt1++;
      if (tx_a[1] === 1'b1) hcnt1++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_cnt(input int idx, input int base, input int bound);
    n_cmp++;
    for (int i = 0; i < bound; i++) begin
      if (dcnt[idx] > base) return;
      cyc(1);
    end
    n_err++;
    $display("FAIL wait_done u%0d: no tx_done_tick within %0d cycles", idx, bound);
  endtask

  task automatic poll_done(input int bound, output bit ok);
    ok = 1'b0;
    n_cmp++;
    for (int i = 0; i < bound; i++) begin
      cyc(1);
      if (done_a[0] === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    n_err++;
    $display("FAIL poll_done: no tx_done_tick within %0d cycles", bound);
  endtask

  // Start a frame on instance 0 and sample tx/busy mid-way through each bit
  // (ticks every 10 clocks: bits are 160 clocks, start bit ends 151..160 clocks in).
  task automatic probe(input logic [7:0] d, output logic [10:0] smp, output logic [10:0] smb);
    tx_start_a[0] = 1'b1;
    din_a[0]      = d;
    cyc(1);
    tx_start_a[0] = 1'b0;
    din_a[0]      = ~d;
    for (int i = 0; i < 11; i++) begin
      cyc((i == 0) ? 80 : 160);
      smp[i] = tx_a[0];
      smb[i] = busy_a[0];
    end
  endtask

  initial begin
    logic [10:0] smp, smb;
    int          base;
    bit          ok;
    int          a5_exp [8];
    logic [7:0]  d;

    a5_exp = '{1, 0, 1, 0, 0, 1, 0, 1};
    rstn = 1'b0;
    tx_start_a[0] = 1'b0;
    tx_start_a[1] = 1'b0;
    din_a[0] = 8'h00;
    din_a[1] = 8'h00;
    s_tick_a[1] = 1'b1;

    cyc(3);
    chk("reset_tx0", tx_a[0], 1);
    chk("reset_busy0", busy_a[0], 0);
    chk("reset_done0", done_a[0], 0);
    chk("reset_tx1", tx_a[1], 1);
    chk("reset_busy1", busy_a[1], 0);
    rstn = 1'b1;
    cyc(2);

    // 8'hA5 at one tick per 10 clocks
    tick_mode = 0;
    base = dcnt[0];
    probe(8'hA5, smp, smb);
    chk("a5_start", smp[0], 0);
    for (int i = 0; i < 8; i++) chk($sformatf("a5_bit%0d", i), smp[1+i], a5_exp[i]);
    chk("a5_bit9", smp[9], (NPAR == 1) ? 0 : 1);
    chk("a5_stop", smp[9+NPAR], 1);
    for (int i = 0; i < 10 + NPAR; i++) chk($sformatf("a5_busy%0d", i), smb[i], 1);
    wait_cnt(0, base, 400);
    cyc(2);
    chk("a5_done_count", dcnt[0] - base, 1);

`ifdef UART_TX_PARITY_EN
    base = dcnt[0];
    probe(8'h07, smp, smb);
    chk("par07_bit", smp[9], 1);
    chk("par07_stop", smp[10], 1);
    wait_cnt(0, base, 400);
    cyc(2);
    base = dcnt[0];
    probe(8'h03, smp, smb);
    chk("par03_bit", smp[9], 0);
    chk("par03_stop", smp[10], 1);
    wait_cnt(0, base, 400);
    cyc(2);
`endif

    // Two stop bits, ticks every clock: frame is (1+8+NPAR)*16 + 32 clocks
    bcnt1 = 0;
    hcnt1 = 0;
    base = dcnt[1];
    tx_start_a[1] = 1'b1;
    din_a[1] = 8'h00;
    cyc(1);
    tx_start_a[1] = 1'b0;
    din_a[1] = 8'hFF;
    wait_cnt(1, base, 400);
    cyc(3);
    chk("sb32_busy_len", bcnt1, 144 + 16 * NPAR + 32);
    chk("sb32_stop_len", hcnt1, 32);
    chk("sb32_done_count", dcnt[1] - base, 1);

    // tx_start held: 8'h55 then 8'hAA, one idle cycle between frames
    tick_mode = 2;
    cyc(2);
    base = dcnt[0];
    tx_start_a[0] = 1'b1;
    din_a[0] = 8'h55;
    cyc(1);
    din_a[0] = 8'hAA;
    poll_done(400, ok);
    if (ok) begin
      chk("b2b_gap_idle", busy_a[0], 0);
      cyc(1);
      chk("b2b_second_accept", busy_a[0], 1);
    end
    poll_done(400, ok);
    tx_start_a[0] = 1'b0;
    cyc(5);
    chk("b2b_frames", dcnt[0] - base, 2);
    chk("b2b_idle_after", busy_a[0], 0);

    // tx_start pulsed mid-frame is ignored
    base = dcnt[0];
    d = 8'($urandom);
    tx_start_a[0] = 1'b1;
    din_a[0] = d;
    cyc(1);
    tx_start_a[0] = 1'b0;
    cyc(40);
    tx_start_a[0] = 1'b1;
    din_a[0] = ~d;
    cyc(1);
    tx_start_a[0] = 1'b0;
    wait_cnt(0, base, 400);
    cyc(20);
    chk("ignore_frames", dcnt[0] - base, 1);
    chk("ignore_idle", busy_a[0], 0);

    // Reset during data bit 3 (clocks 64..79 after accept)
    base = dcnt[0];
    tx_start_a[0] = 1'b1;
    din_a[0] = 8'($urandom);
    cyc(1);
    tx_start_a[0] = 1'b0;
    repeat (70) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_mid_tx", tx_a[0], 1);
    chk("rst_mid_busy", busy_a[0], 0);
    repeat (3) @(posedge clk);
    #3;
    rstn = 1'b1;
    cyc(3);
    chk("rst_mid_no_done", dcnt[0] - base, 0);
    base = dcnt[0];
    tx_start_a[0] = 1'b1;
    din_a[0] = 8'($urandom);
    cyc(1);
    tx_start_a[0] = 1'b0;
    wait_cnt(0, base, 400);
    cyc(2);
    chk("rst_after_frame", dcnt[0] - base, 1);

    // Randomized frames, tick patterns and hold lengths
    for (int k = 0; k < 12; k++) begin
      tick_mode = $urandom_range(0, 2);
      cyc($urandom_range(1, 6));
      base = dcnt[0];
      tx_start_a[0] = 1'b1;
      din_a[0] = 8'($urandom);
      cyc($urandom_range(1, 3));
      tx_start_a[0] = 1'b0;
      din_a[0] = 8'($urandom);
      wait_cnt(0, base, 6000);
      cyc(2);
      chk($sformatf("rand%0d_frames", k), dcnt[0] - base, 1);
    end

    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART datapath: takes a parallel byte on a start strobe and shifts out one frame (start bit, DBIT data bits LSB first, optional parity, stop bit(s)) on `tx`. Bit timing comes entirely from the external oversampling tick `s_tick`, 16 ticks per bit, produced by the baud timer. It is the transmit-direction counterpart of the receive path.

## Interface
- `DBIT`, default 8: data bits per frame, legal range 5..8.
- `SB_TICK`, default 16: stop-bit length in ticks. 16 = 1 stop bit, 24 = 1.5 stop bits, 32 = 2 stop bits.

- `clk`  input  1: single clock, rising edge.
- `rstn`  input  1: reset, asynchronous, active-low.
- `tx_start`  input  1: level, request to send `din`. Sampled only in IDLE.
- `s_tick`  input  1: one-cycle oversampling pulse, 16 per bit period.
- `din`  input  DBIT: data byte, captured on accept.
- `tx`  output  1: serial line, registered, idle high.
- `busy`  output  1: high whenever state ≠ IDLE.
- `tx_done_tick`  output  1: one-cycle pulse when the frame completes.

## Operation
- States: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- Registers:
  - `s_reg`: 5-bit tick counter, wide enough for SB_TICK = 32.
  - `n_reg`: 3-bit bit counter.
  - `b_reg`: DBIT-bit shift register.
  - `tx_reg`: output register.
- IDLE
  - `tx` = 1.
  - On `tx_start` = 1: `b_reg` ← `din`, `s_reg` ← 0, go to START.
- START
  - `tx` = 0.
  - Each `s_tick` increments `s_reg`.
  - On the tick with `s_reg` = 15: `s_reg` ← 0, `n_reg` ← 0, go to DATA.
- DATA
  - `tx` = `b_reg[0]`.
  - On the tick with `s_reg` = 15: `b_reg` shifts right and `s_reg` ← 0.
  - If `n_reg` = DBIT-1, go to PARITY (or STOP). Otherwise `n_reg` increments.
- PARITY
  - `tx` = even parity, i.e. the XOR of all captured data bits. This value is computed at accept time and held in a 1-bit register.
  - After 16 ticks, go to STOP.
- STOP
  - `tx` = 1.
  - On the tick with `s_reg` = SB_TICK-1: pulse `tx_done_tick`, go to IDLE.
- `s_tick` is ignored in IDLE. `tx_start` is ignored outside IDLE.
- `din` changes after accept do not affect the frame in flight.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `tx_done_tick` = 0, state IDLE, all counters 0.
- Accept and output latency:
  - `tx_start` is accepted on the clock edge where state is IDLE.
  - On that same edge, `tx` falls to 0 and `busy` rises to 1.
  - Latency from `tx_start` to the `tx` fall is therefore 1 cycle.
- Start bit length: from entry to START until the 16th tick. The first tick phase is not aligned to the accept, so the start bit lasts between 15 and 16 tick periods. Every later bit lasts exactly 16 tick periods; the stop bit lasts SB_TICK periods.
- All state transitions occur on the clock edge that samples the qualifying `s_tick`.
- `tx_done_tick` end of frame:
  - `tx_done_tick` is high for exactly the one cycle after the final stop tick. In that cycle state is IDLE and `busy` = 0.
  - If `tx_start` is held high through the end of a frame, the next frame is accepted on the edge where state = IDLE, i.e. the cycle `tx_done_tick` is high.
  - There are no back-to-back frames without one IDLE cycle.
- Reset mid-frame: `tx` returns to 1 asynchronously, the frame is abandoned, and no `tx_done_tick` is generated.
- Ticks at every cycle (`s_tick` tied high) are legal: a bit then lasts 16 clocks.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
  - Defined: PARITY state and parity register present. The frame is 1 + DBIT + 1 + stop bits long, with even parity.
  - Undefined: no PARITY state or register; DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - `OVERSAMPLE` = 16;
  - `TICK_CNT_W` = 5.
- No sub-module is needed. The tick source is the external baud timer, and the counters and shift register are inline.

## Test plan
- 16 ticks per bit at 1 tick every 10 clks, DBIT = 8, SB_TICK = 16, no parity. Send `din` = 8'hA5 → `tx` shows 0 for 150–160 clks, then 1,0,1,0,0,1,0,1 at 160 clks each, then 1 for 160 clks. One `tx_done_tick`, and `busy` is high throughout the frame.
- Parity build, `din` = 8'h07 (three ones) → parity bit = 1. `din` = 8'h03 → parity bit = 0. Frame has 11 bit periods.
- SB_TICK = 32 with `s_tick` tied high → stop bit is 32 clks, and `tx_done_tick` is 1 cycle after the 32nd stop clock.
- `tx_start` held high with `din` = 8'h55 then 8'hAA → two frames separated by exactly 1 IDLE cycle, second frame carries 8'hAA. A `din` change mid-frame does not corrupt the first frame.
- `tx_start` pulsed while `busy` = 1 → ignored. No second frame, and the current frame is unchanged.
- Assert `rstn` = 0 during DATA bit 3 → `tx` = 1 immediately, `busy` = 0, no `tx_done_tick`. A new frame after reset release is correct.
